// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the DVP camera transmitter:
// frame FSM states and the eight RGB565 colour-bar values.
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_t;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_cam_tx_if.sv
// Upstream RGB565 pixel stream: ready/valid, one pixel per accepted handshake.
interface dvp_cam_tx_if;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;

    modport master (output pix_valid, output pix_data, input pix_ready);
    modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/dvp_color_bar.sv
// Combinational x -> RGB565 colour-bar lookup; bar = floor(x*8/H_ACTIVE),
// found by comparing x*8 against the seven bar boundaries instead of dividing.
module dvp_color_bar
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int XW       = 10
) (
    input  logic [XW-1:0] x,
    output logic [15:0]   rgb
);

    logic [6:0] above;
    logic [2:0] bar;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_thr
            assign above[gi] = ((32'(x) << 3) >= 32'((gi + 1) * H_ACTIVE));
        end
    endgenerate

    always_comb begin
        bar = 3'd0;
        for (int i = 0; i < 7; i++) begin
            bar = bar + 3'(above[i]);
        end
    end

    assign rgb = bar_color(bar);

endmodule

// File: rtl/dvp_cam_tx.sv
// DVP sensor-side transmitter: generates pclk = clk/2, vsync, href and RGB565
// bytes (high first) from an upstream stream or internal colour bars.
module dvp_cam_tx
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 160,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 16,
    parameter int V_FRONT     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         pattern_en,
    dvp_cam_tx_if.slave  pix,
    output logic         cmos_pclk,
    output logic         cmos_vsync,
    output logic         cmos_href,
    output logic [7:0]   cmos_db,
    output logic         busy,
    output logic         frame_done,
    output logic         underrun
);

    localparam int L     = 2 * H_ACTIVE + H_BLANK;
    localparam int TOTAL = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW    = $clog2(L);
    localparam int VW    = $clog2(TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(L - 1);

    state_t        state_reg, state_next;
    logic [HW-1:0] hcnt_reg, hcnt_next;
    logic [VW-1:0] vcnt_reg, vcnt_next;
    logic [VW-1:0] last_line;
    logic          ph_reg;
    logic          pat_reg;
    logic [7:0]    lo_reg;
    logic          pclk_reg, vsync_reg, href_reg, busy_reg, done_reg, underrun_reg, ready_reg;
    logic [7:0]    db_reg;
    logic          frame_end, step, byte_active, high_byte;
    logic [15:0]   bar_rgb;

    // Next pclk period position; applied only on a fall (or on the IDLE exit).
    always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        vcnt_next  = vcnt_reg;
        frame_end  = 1'b0;
        case (state_reg)
            VSYNC:   last_line = VW'(VSYNC_LINES - 1);
            VBACK:   last_line = VW'(V_BACK - 1);
            ACTIVE:  last_line = VW'(V_ACTIVE - 1);
            VFRONT:  last_line = VW'(V_FRONT - 1);
            default: last_line = '0;
        endcase
        if (state_reg == IDLE) begin
            state_next = VSYNC;
            hcnt_next  = '0;
            vcnt_next  = '0;
        end else if (hcnt_reg != H_LAST) begin
            hcnt_next = hcnt_reg + HW'(1);
        end else begin
            hcnt_next = '0;
            if (vcnt_reg != last_line) begin
                vcnt_next = vcnt_reg + VW'(1);
            end else begin
                vcnt_next = '0;
                case (state_reg)
                    VSYNC:  state_next = VBACK;
                    VBACK:  state_next = ACTIVE;
                    ACTIVE: state_next = VFRONT;
                    VFRONT: begin
                        frame_end  = 1'b1;
                        state_next = en ? VSYNC : IDLE;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // A fall happens when ph is low; the IDLE exit acts as the first fall.
    assign step        = (state_reg == IDLE) ? en : ~ph_reg;
    assign byte_active = (state_next == ACTIVE) && (32'(hcnt_next) < 32'(2 * H_ACTIVE));
    assign high_byte   = ~hcnt_next[0];

    dvp_color_bar #(
        .H_ACTIVE (H_ACTIVE),
        .XW       (HW)
    ) u_bar (
        .x   (hcnt_next >> 1),
        .rgb (bar_rgb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            hcnt_reg     <= '0;
            vcnt_reg     <= '0;
            ph_reg       <= 1'b0;
            pat_reg      <= 1'b0;
            lo_reg       <= '0;
            pclk_reg     <= 1'b0;
            vsync_reg    <= 1'b0;
            href_reg     <= 1'b0;
            db_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            underrun_reg <= 1'b0;
            ready_reg    <= 1'b0;
        end else begin
            pclk_reg <= ph_reg;
            done_reg <= 1'b0;
            busy_reg <= (state_reg != IDLE) || en;
            // Ready is raised on the rise before the high-byte fall so the
            // handshake edge is that fall itself.
            ready_reg <= (state_reg != IDLE) && ph_reg && byte_active && high_byte && !pat_reg;
            if (step) begin
                state_reg <= state_next;
                hcnt_reg  <= hcnt_next;
                vcnt_reg  <= vcnt_next;
                ph_reg    <= (state_next != IDLE);
                done_reg  <= frame_end;
                if (state_reg == IDLE || frame_end) begin
                    pat_reg <= pattern_en;
                end
                vsync_reg <= (state_next == VSYNC);
                href_reg  <= byte_active;
                if (!byte_active) begin
                    db_reg <= '0;
                end else if (!high_byte) begin
                    db_reg <= lo_reg;
                end else if (pat_reg) begin
                    {db_reg, lo_reg} <= bar_rgb;
                end else if (pix.pix_valid) begin
                    {db_reg, lo_reg} <= pix.pix_data;
                end else begin
                    db_reg       <= '0;
                    lo_reg       <= '0;
                    underrun_reg <= 1'b1;
                end
            end else begin
                ph_reg <= 1'b0;
            end
        end
    end

    assign cmos_pclk     = pclk_reg;
    assign cmos_vsync    = vsync_reg;
    assign cmos_href     = href_reg;
    assign cmos_db       = db_reg;
    assign busy          = busy_reg;
    assign frame_done    = done_reg;
    assign underrun      = underrun_reg;
    assign pix.pix_ready = ready_reg;

endmodule

// File: tb/tb_dvp_cam_tx.sv
// Bench for dvp_cam_tx: records every pclk rise like a receiver would and
// compares it with a frame model computed from period index arithmetic.
module tb_dvp_cam_tx;

    localparam int H_ACTIVE    = 4;
    localparam int V_ACTIVE    = 2;
    localparam int H_BLANK     = 6;
    localparam int VSYNC_LINES = 1;
    localparam int V_BACK      = 1;
    localparam int V_FRONT     = 1;
    localparam int LINE_PCLK   = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_PCLK  = LINE_PCLK * (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT);
    localparam int FRAME_CLK   = 2 * FRAME_PCLK;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       pattern_en = 1'b0;
    logic       cmos_pclk, cmos_vsync, cmos_href, busy, frame_done, underrun;
    logic [7:0] cmos_db;

    logic [15:0] plan_data  [0:63];
    logic        plan_valid [0:63];
    logic [5:0]  src_slot = '0;
    logic [15:0] bars [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    dvp_cam_tx_if pix ();
    assign pix.pix_valid = plan_valid[src_slot];
    assign pix.pix_data  = plan_data[src_slot];

    dvp_cam_tx #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pattern_en (pattern_en),
        .pix        (pix),
        .cmos_pclk  (cmos_pclk),
        .cmos_vsync (cmos_vsync),
        .cmos_href  (cmos_href),
        .cmos_db    (cmos_db),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Posedge counter and receiver-style monitor sampling on the opposite edge.
    int         ncount = 0;
    bit         mon_on = 1'b0;
    logic       prev_pclk = 1'b0;
    logic [9:0] rise_q[$];
    int         rise_t[$];
    int         fd_t[$];
    int         rdy_cnt = 0;

    initial forever begin
        @(posedge clk);
        ncount++;
    end

    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            if (cmos_pclk && !prev_pclk) begin
                rise_q.push_back({cmos_vsync, cmos_href, cmos_db});
                rise_t.push_back(ncount);
            end
            if (pix.pix_ready) rdy_cnt++;
            if (frame_done) fd_t.push_back(ncount);
        end
        prev_pclk = cmos_pclk;
    end

    // Upstream source: moves to the next planned pixel after each ready pulse.
    initial forever begin
        @(negedge clk);
        if (pix.pix_ready) begin
            @(negedge clk);
            src_slot = src_slot + 6'd1;
        end
    end

    // Expected {vsync, href, db} seen at the j-th pclk rise since the IDLE exit.
    function automatic logic [9:0] exp_rise(input int j, input bit pat);
        int f, p, line, h, x, slot;
        logic [15:0] c;
        logic [7:0]  b;
        logic        vs, hr;
        f    = j / FRAME_PCLK;
        p    = j % FRAME_PCLK;
        line = p / LINE_PCLK;
        h    = p % LINE_PCLK;
        vs   = (line < VSYNC_LINES);
        hr   = 1'b0;
        b    = 8'h00;
        if (line >= VSYNC_LINES + V_BACK && line < VSYNC_LINES + V_BACK + V_ACTIVE
            && h < 2 * H_ACTIVE) begin
            hr   = 1'b1;
            x    = h / 2;
            slot = f * V_ACTIVE * H_ACTIVE + (line - VSYNC_LINES - V_BACK) * H_ACTIVE + x;
            if (pat) c = bars[(x * 8) / H_ACTIVE];
            else     c = plan_valid[slot] ? plan_data[slot] : 16'h0000;
            b = (h % 2 == 0) ? c[15:8] : c[7:0];
        end
        return {vs, hr, b};
    endfunction

    task automatic run_test(input int nf, input bit pat, input int vpct, input bit det, input bit ur);
        int  r0;
        bit  exp_ur;
        pattern_en = pat;
        for (int i = 0; i < 64; i++) begin
            plan_data[i]  = 16'($urandom);
            plan_valid[i] = ($urandom_range(99) < vpct);
        end
        if (det) begin
            plan_data[0] = 16'h1234; plan_data[1] = 16'h5678;
            plan_data[2] = 16'h9ABC; plan_data[3] = 16'hDEF0;
            for (int i = 0; i < 4; i++) plan_valid[i] = 1'b1;
        end
        if (ur) plan_valid[1] = 1'b0;
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  32'({cmos_pclk, cmos_vsync, cmos_href, cmos_db, busy, frame_done, underrun, pix.pix_ready}),
                  32'h0);
        src_slot = '0;
        rise_q.delete();
        rise_t.delete();
        fd_t.delete();
        rdy_cnt = 0;
        mon_on  = 1'b1;
        rst     = 1'b0;
        r0      = ncount;
        while (fd_t.size() < nf && ncount < r0 + nf * FRAME_CLK + 40) begin
            @(negedge clk);
            if (ncount == r0 + (nf - 1) * FRAME_CLK + 70) en = 1'b0;
        end
        repeat (8) @(negedge clk);
        check_val("idle_busy", 32'(busy), 32'h0);
        check_val("idle_pclk", 32'(cmos_pclk), 32'h0);
        mon_on = 1'b0;
        check_val("frame_done_count", 32'(fd_t.size()), 32'(nf));
        for (int k = 0; k < fd_t.size() && k < nf; k++)
            check_val("frame_done_time", 32'(fd_t[k] - r0), 32'(1 + FRAME_CLK * (k + 1)));
        check_val("rise_count", 32'(rise_q.size()), 32'(nf * FRAME_PCLK));
        for (int j = 0; j < rise_q.size() && j < nf * FRAME_PCLK; j++) begin
            check_val("rise_bus", 32'(rise_q[j]), 32'(exp_rise(j, pat)));
            check_val("rise_time", 32'(rise_t[j] - r0), 32'(2 + 2 * j));
        end
        check_val("ready_pulses", 32'(rdy_cnt), pat ? 32'h0 : 32'(nf * V_ACTIVE * H_ACTIVE));
        exp_ur = 1'b0;
        if (!pat)
            for (int i = 0; i < nf * V_ACTIVE * H_ACTIVE; i++)
                if (!plan_valid[i]) exp_ur = 1'b1;
        check_val("underrun", 32'(underrun), 32'(exp_ur));
        $display("run frames=%0d pattern=%0d rises=%0d ready=%0d underrun=%0b",
                 nf, pat, rise_q.size(), rdy_cnt, underrun);
    endtask

    task automatic abort_test();
        int r0;
        pattern_en = 1'b0;
        for (int i = 0; i < 64; i++) begin
            plan_data[i]  = 16'($urandom);
            plan_valid[i] = 1'b1;
        end
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        src_slot = '0;
        rst = 1'b0;
        r0  = ncount;
        while (!(cmos_href && ncount > r0 + 60) && ncount < r0 + 200) @(negedge clk);
        check_val("abort_href_before", 32'(cmos_href), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_outputs", 32'({cmos_href, cmos_db, busy, cmos_vsync, cmos_pclk}), 32'h0);
        rise_q.delete();
        rise_t.delete();
        mon_on = 1'b1;
        rst    = 1'b0;
        r0     = ncount;
        repeat (7) @(negedge clk);
        mon_on = 1'b0;
        check_val("restart_rises", 32'(rise_q.size()), 32'd3);
        if (rise_q.size() > 0) begin
            check_val("restart_bus", 32'(rise_q[0]), 32'(exp_rise(0, 1'b0)));
            check_val("restart_time", 32'(rise_t[0] - r0), 32'd2);
        end
        $display("run abort_restart rises=%0d vsync_first=%0b", rise_q.size(),
                 (rise_q.size() > 0) ? rise_q[0][9] : 1'b0);
        en  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            plan_data[i]  = '0;
            plan_valid[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        run_test(1, 1'b1, 100, 1'b0, 1'b0);
        run_test(1, 1'b0, 100, 1'b1, 1'b0);
        run_test(3, 1'b0, 100, 1'b0, 1'b1);
        run_test(2, 1'b0, 70,  1'b0, 1'b0);
        run_test(2, 1'b1, 50,  1'b0, 1'b0);
        abort_test();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dvp_cam_tx.md
Name: dvp_cam_tx

Overview:
DVP sensor-side transmitter that emits the 8-bit parallel camera protocol: cmos_pclk, cmos_vsync, cmos_href and cmos_db, sent as RGB565 with the high byte first. It replaces the physical sensor in loopback and simulation, so the capture path can be exercised with no camera fitted. Pixels come from an upstream ready/valid stream or from an internal colour-bar generator. Frame timing is parameterised and counted in pclk periods.

Parameters:
H_ACTIVE, 640, pixels per active line (each pixel is 2 bytes, so 2 pclk)
V_ACTIVE, 480, active lines per frame
H_BLANK, 160, pclk periods with href low after each line's bytes
VSYNC_LINES, 4, lines with vsync high
V_BACK, 16, lines after vsync before the first active line
V_FRONT, 8, lines after the last active line

Ports:
clk  in  1  system clock; cmos_pclk = clk/2
rst  in  1  synchronous, active-high reset
en  in  1  frame enable, sampled only at frame boundaries
pattern_en  in  1  1 = internal colour bars; 0 = upstream stream; sampled at frame start
pix_valid  in  1  upstream pixel valid
pix_data  in  16  upstream RGB565 pixel
pix_ready  out  1  one-clk pulse; pixel accepted when pix_ready & pix_valid
cmos_pclk  out  1  generated pixel clock
cmos_vsync  out  1  active-high vertical sync
cmos_href  out  1  active-high line valid
cmos_db  out  8  data byte
busy  out  1  high while a frame is in progress
frame_done  out  1  one-clk pulse at the end of the V_FRONT period
underrun  out  1  sticky; set when a pixel is needed and pix_valid is low

Behaviour:
- Reset: every output is 0, the FSM goes to IDLE and all counters clear. A reset mid-frame aborts immediately, with no partial-line completion.
- Phase bit ph toggles every clk while not IDLE; cmos_pclk is registered from ph.
- "Fall" is the clk where cmos_pclk goes 1->0. vsync, href and db change only on fall, so they are stable at the receiver's rising-edge sample.
- In IDLE, cmos_pclk is held at 0.
- Line length L = 2*H_ACTIVE + H_BLANK pclk. A pclk counter hcnt runs 0..L-1 and wraps; a line counter vcnt advances on wrap.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - IDLE -> VSYNC: on en=1. pattern_en is latched here.
  - VSYNC -> VBACK: after VSYNC_LINES lines.
  - VBACK -> ACTIVE: after V_BACK lines.
  - ACTIVE -> VFRONT: after V_ACTIVE lines.
  - VFRONT end: frame_done pulses. If en=1, go to VSYNC with no gap pclk; otherwise go to IDLE.
  - Dropping en mid-frame completes the current frame.
- cmos_vsync = 1 for the whole of VSYNC; cmos_href = 0 there.
- In ACTIVE, cmos_href = 1 for hcnt 0..2*H_ACTIVE-1, then 0. cmos_db = 0 whenever href = 0.
- Pixel fetch:
  - On the fall that starts an even hcnt (high byte), pix_ready pulses in that same clk.
  - If pix_valid = 1: drive db = pix_data[15:8] and latch pix_data[7:0] for the next fall.
  - If pix_valid = 0: send 0x0000 and set underrun.
  - pix_ready is never asserted when pattern_en is latched, nor outside active bytes.
- Colour bars: bar = (x*8)/H_ACTIVE, where x is the pixel index within the line. The 8 colours are FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- busy = 1 from the IDLE exit up to and including the frame_done clk.
- underrun clears only on rst.
- Counter widths come from $clog2 of the maximum count (L, total lines). There is no overflow by construction.

Decomposition:
- Package dvp_tx_pkg holds:
  - the state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT);
  - the 8 RGB565 colour-bar constants.
- One sub-module, dvp_color_bar: combinational x -> RGB565 lookup, parameterised on H_ACTIVE.

Test Plan:
All tests use H_ACTIVE=4, V_ACTIVE=2, H_BLANK=6, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, giving L=14 pclk and 5 lines = 70 pclk = 140 clk per frame.
- Reset: hold rst for 3 clk with en=1 -> every output 0; first rising cmos_pclk comes after the IDLE exit; vsync high for exactly 14 pclk.
- Pattern frame: pattern_en=1, en=1 for one frame.
  - Each active line's bytes are FF FF 07 FF F8 1F 00 1F, with href high for exactly 8 pclk and then low for 6.
  - pix_ready is never asserted.
  - frame_done pulses once, 140 clk after the IDLE exit.
- Stream frame: pattern_en=0, pix_valid=1, pix_data = 0x1234, 0x5678, 0x9ABC, 0xDEF0, ...
  - db sequence is 12 34 56 78 9A BC DE F0.
  - 8 pix_ready pulses per frame (4 per line).
  - underrun stays 0.
- Underrun: drop pix_valid at the 2nd pixel -> that pixel's bytes are 00 00; underrun goes high and stays high through later frames until rst.
- Back-to-back and stop: with en held at 1, the next vsync rises on the pclk fall immediately after frame_done. Dropping en mid-ACTIVE -> the current frame completes, then IDLE, busy=0, pclk held at 0.
- Reset mid-line: assert rst during an active byte -> the next clk has href=0, db=0, busy=0; after release the frame restarts from VSYNC.
